// File: rtl/parking_entry_frontend_pkg.sv
// ---------------------------------------------------------------------------
// parking_entry_frontend_pkg
//   Shared constants for the parking entry front end: PIN width, keypad FSM
//   state encodings, gate FSM state encodings and a small width helper.
//   No ports (package).
// ---------------------------------------------------------------------------
package parking_entry_frontend_pkg;

    localparam int CODE_W = 16;

    // Keypad FSM states
    localparam logic [2:0] KP_IDLE    = 3'd0;
    localparam logic [2:0] KP_COLLECT = 3'd1;
    localparam logic [2:0] KP_PRESENT = 3'd2;
    localparam logic [2:0] KP_RELEASE = 3'd3;
    localparam logic [2:0] KP_LOCKED  = 3'd4;

    // Gate FSM states
    localparam logic [2:0] GT_CLOSED  = 3'd0;
    localparam logic [2:0] GT_OPENING = 3'd1;
    localparam logic [2:0] GT_OPEN    = 3'd2;
    localparam logic [2:0] GT_CLOSING = 3'd3;
    localparam logic [2:0] GT_ACK     = 3'd4;

    // Bits needed to hold 0..v-1, never less than one bit.
    function automatic int width_for(input int v);
        int w;
        w = $clog2(v);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/parking_gate_motor.sv
// ---------------------------------------------------------------------------
// parking_gate_motor
//   Barrier motor controller: gate FSM plus an up/down position counter that
//   runs between 0 (closed) and GATE_TRAVEL (fully open).
// Ports
//   clk, rst      clock, synchronous active-high reset
//   open_gate     request to raise the barrier
//   close_gate    request to lower the barrier (level, held until gate_ack)
//   gate_ack      one-cycle pulse after a close completes
//   motor_up      motor drive, raising
//   motor_down    motor drive, lowering
//   gate_is_open  position == GATE_TRAVEL
//   state         current gate FSM state, for observation
// ---------------------------------------------------------------------------
module parking_gate_motor
    import parking_entry_frontend_pkg::*;
#(
    parameter int GATE_TRAVEL = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       open_gate,
    input  logic       close_gate,
    output logic       gate_ack,
    output logic       motor_up,
    output logic       motor_down,
    output logic       gate_is_open,
    output logic [2:0] state
);

    localparam int POS_W = width_for(GATE_TRAVEL + 1);
    localparam logic [POS_W-1:0] POS_TOP  = POS_W'(GATE_TRAVEL);
    localparam logic [POS_W-1:0] POS_ZERO = '0;
    localparam logic [POS_W-1:0] POS_ONE  = POS_W'(1);

    logic [POS_W-1:0] pos;

    // Close has priority over open whenever both are requested.
    logic open_req;
    assign open_req = open_gate & ~close_gate;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= GT_CLOSED;
            pos   <= POS_ZERO;
        end else begin
            case (state)
                GT_CLOSED: begin
                    if (open_req) state <= GT_OPENING;
                end
                GT_OPENING: begin
                    if (close_gate) begin
                        // Reverse in place; a barrier that never left the
                        // closed position is acknowledged straight away so the
                        // controller holding close_gate is not left waiting.
                        state <= (pos == POS_ZERO) ? GT_ACK : GT_CLOSING;
                    end else begin
                        pos <= pos + POS_ONE;
                        if (pos + POS_ONE == POS_TOP) state <= GT_OPEN;
                    end
                end
                GT_OPEN: begin
                    if (close_gate) state <= GT_CLOSING;
                end
                GT_CLOSING: begin
                    if (open_req) begin
                        // Reversal cancels the close: no gate_ack.
                        state <= (pos == POS_TOP) ? GT_OPEN : GT_OPENING;
                    end else begin
                        pos <= pos - POS_ONE;
                        if (pos == POS_ONE) state <= GT_ACK;
                    end
                end
                GT_ACK: begin
                    state <= GT_CLOSED;
                end
                default: begin
                    state <= GT_CLOSED;
                    pos   <= POS_ZERO;
                end
            endcase
        end
    end

    assign motor_up     = (state == GT_OPENING);
    assign motor_down   = (state == GT_CLOSING);
    assign gate_ack     = (state == GT_ACK);
    assign gate_is_open = (pos == POS_TOP);

endmodule

// File: rtl/parking_entry_frontend.sv
// ---------------------------------------------------------------------------
// parking_entry_frontend
//   Field-side front end of the parking controller. Collects keypad digits
//   into a PIN, presents it to the controller, drives the barrier motor and
//   locks the keypad while the controller raises an alarm.
// Ports
//   clk, rst       clock, synchronous active-high reset
//   key_valid      one-cycle strobe, key_value is a new digit
//   key_value      digit value
//   key_clear      one-cycle strobe, discard the partial PIN
//   key_enter      one-cycle strobe, submit the PIN
//   open_gate      controller request to raise the barrier
//   close_gate     controller request to lower the barrier (level)
//   wrong_ping     controller alarm
//   blocked_gate   controller alarm
//   code           submitted PIN, first digit in the top nibble
//   code_ack       code is valid (level)
//   gate_ack       one-cycle pulse when a close completes
//   motor_up       motor drive, raising
//   motor_down     motor drive, lowering
//   gate_is_open   barrier fully open
//   keypad_locked  keypad FSM is locked by an alarm
//
// PIN handshake: code_ack is a level that stays high for exactly ACK_HOLD
// cycles while code is held stable; it is then low for at least one cycle
// with code returned to 0, so the controller always sees a falling edge
// before a new PIN can be presented. There is no back-pressure.
// DIGITS*DIGIT_W must equal the 16-bit PIN width.
// ---------------------------------------------------------------------------
module parking_entry_frontend
    import parking_entry_frontend_pkg::*;
#(
    parameter int DIGITS        = 4,
    parameter int DIGIT_W       = 4,
    parameter int ACK_HOLD      = 2,
    parameter int GATE_TRAVEL   = 8,
    parameter int ENTRY_TIMEOUT = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               key_valid,
    input  logic [DIGIT_W-1:0] key_value,
    input  logic               key_clear,
    input  logic               key_enter,
    input  logic               open_gate,
    input  logic               close_gate,
    input  logic               wrong_ping,
    input  logic               blocked_gate,
    output logic [CODE_W-1:0]  code,
    output logic               code_ack,
    output logic               gate_ack,
    output logic               motor_up,
    output logic               motor_down,
    output logic               gate_is_open,
    output logic               keypad_locked
);

    localparam int CNT_W  = width_for(DIGITS + 1);
    localparam int IDLE_W = width_for(ENTRY_TIMEOUT);
    localparam int HOLD_W = width_for(ACK_HOLD);

    localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(DIGITS);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(ENTRY_TIMEOUT - 1);
    localparam logic [IDLE_W-1:0] IDLE_ONE  = IDLE_W'(1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(ACK_HOLD - 1);
    localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);

    logic [2:0]        kp_state;
    logic [CODE_W-1:0] shreg;
    logic [CNT_W-1:0]  count;
    logic [IDLE_W-1:0] idle_cnt;
    logic [HOLD_W-1:0] hold_cnt;
    logic [2:0]        gate_state;

    logic alarm;
    logic digit_only;
    logic [CODE_W-1:0] shifted;

    assign alarm      = wrong_ping | blocked_gate;
    // A digit that arrives together with clear or enter is dropped.
    assign digit_only = key_valid & ~key_clear & ~key_enter;
    assign shifted    = {shreg[CODE_W-DIGIT_W-1:0], key_value};

    always_ff @(posedge clk) begin
        if (rst) begin
            kp_state <= KP_IDLE;
            shreg    <= '0;
            count    <= '0;
            idle_cnt <= '0;
            hold_cnt <= '0;
            code     <= '0;
        end else if (alarm) begin
            // Alarm wins over everything and only rst leaves LOCKED.
            kp_state <= KP_LOCKED;
            shreg    <= '0;
            count    <= '0;
            idle_cnt <= '0;
            hold_cnt <= '0;
            code     <= '0;
        end else begin
            case (kp_state)
                KP_IDLE: begin
                    if (digit_only) begin
                        shreg    <= shifted;
                        count    <= CNT_ONE;
                        idle_cnt <= '0;
                        kp_state <= KP_COLLECT;
                    end
                end
                KP_COLLECT: begin
                    if (key_clear) begin
                        shreg    <= '0;
                        count    <= '0;
                        idle_cnt <= '0;
                        kp_state <= KP_IDLE;
                    end else if (key_enter) begin
                        // A short PIN is discarded but the user stays in
                        // COLLECT to retype it.
                        if (count == CNT_FULL) begin
                            code     <= shreg;
                            hold_cnt <= '0;
                            kp_state <= KP_PRESENT;
                        end
                        shreg    <= '0;
                        count    <= '0;
                        idle_cnt <= '0;
                    end else if (key_valid) begin
                        if (count != CNT_FULL) begin
                            shreg <= shifted;
                            count <= count + CNT_ONE;
                        end
                        idle_cnt <= '0;
                    end else if (idle_cnt == IDLE_LAST) begin
                        shreg    <= '0;
                        count    <= '0;
                        idle_cnt <= '0;
                        kp_state <= KP_IDLE;
                    end else begin
                        idle_cnt <= idle_cnt + IDLE_ONE;
                    end
                end
                KP_PRESENT: begin
                    if (hold_cnt == HOLD_LAST) begin
                        code     <= '0;
                        kp_state <= KP_RELEASE;
                    end else begin
                        hold_cnt <= hold_cnt + HOLD_ONE;
                    end
                end
                KP_RELEASE: begin
                    kp_state <= KP_IDLE;
                end
                KP_LOCKED: begin
                    kp_state <= KP_LOCKED;
                end
                default: begin
                    kp_state <= KP_IDLE;
                    shreg    <= '0;
                    count    <= '0;
                    code     <= '0;
                end
            endcase
        end
    end

    assign code_ack      = (kp_state == KP_PRESENT);
    assign keypad_locked = (kp_state == KP_LOCKED);

    parking_gate_motor #(
        .GATE_TRAVEL (GATE_TRAVEL)
    ) u_gate (
        .clk          (clk),
        .rst          (rst),
        .open_gate    (open_gate),
        .close_gate   (close_gate),
        .gate_ack     (gate_ack),
        .motor_up     (motor_up),
        .motor_down   (motor_down),
        .gate_is_open (gate_is_open),
        .state        (gate_state)
    );

    // The gate state is kept for observation only; nothing here needs it.
    logic unused_gate_state;
    assign unused_gate_state = ^gate_state;

endmodule

// File: tb/tb_parking_entry_frontend.sv
// ---------------------------------------------------------------------------
// tb_parking_entry_frontend
//   Self-checking bench for parking_entry_frontend: directed PIN table,
//   hand-written gate/timeout/lock sequences and randomized traffic, all
//   compared every cycle against a behavioural model of the keypad and gate.
// ---------------------------------------------------------------------------
module tb_parking_entry_frontend;

    localparam int DIGITS        = 4;
    localparam int DIGIT_W       = 4;
    localparam int ACK_HOLD      = 2;
    localparam int GATE_TRAVEL   = 8;
    localparam int ENTRY_TIMEOUT = 64;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        key_valid, key_clear, key_enter;
    logic [3:0]  key_value;
    logic        open_gate, close_gate, wrong_ping, blocked_gate;
    logic [15:0] code;
    logic        code_ack, gate_ack, motor_up, motor_down, gate_is_open, keypad_locked;

    parking_entry_frontend #(
        .DIGITS        (DIGITS),
        .DIGIT_W       (DIGIT_W),
        .ACK_HOLD      (ACK_HOLD),
        .GATE_TRAVEL   (GATE_TRAVEL),
        .ENTRY_TIMEOUT (ENTRY_TIMEOUT)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .key_valid     (key_valid),
        .key_value     (key_value),
        .key_clear     (key_clear),
        .key_enter     (key_enter),
        .open_gate     (open_gate),
        .close_gate    (close_gate),
        .wrong_ping    (wrong_ping),
        .blocked_gate  (blocked_gate),
        .code          (code),
        .code_ack      (code_ack),
        .gate_ack      (gate_ack),
        .motor_up      (motor_up),
        .motor_down    (motor_down),
        .gate_is_open  (gate_is_open),
        .keypad_locked (keypad_locked)
    );

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // ---------------- reference model ----------------
    // Keypad: digits typed so far, whether an entry is in progress, idle
    // cycles, remaining presentation cycles, release cycle pending, lock.
    int          m_digits[$];
    bit          m_collect;
    int          m_idle;
    int          m_ack_left;
    bit          m_release;
    bit          m_locked;
    logic [15:0] m_code;
    // Gate: position plus what the barrier is doing right now.
    int          m_pos;
    bit          m_up, m_dn, m_ack;

    task automatic model_step();
        logic [15:0] packed_pin;
        // keypad
        if (rst) begin
            m_digits.delete(); m_collect = 0; m_idle = 0; m_ack_left = 0;
            m_release = 0; m_locked = 0; m_code = '0;
        end else if (wrong_ping || blocked_gate) begin
            m_digits.delete(); m_collect = 0; m_idle = 0; m_ack_left = 0;
            m_release = 0; m_locked = 1; m_code = '0;
        end else if (m_locked) begin
            // keys ignored
        end else if (m_ack_left > 0) begin
            m_ack_left--;
            if (m_ack_left == 0) begin
                m_code = '0;
                m_release = 1;
            end
        end else if (m_release) begin
            m_release = 0;
        end else if (key_clear) begin
            if (m_collect) begin
                m_digits.delete(); m_collect = 0; m_idle = 0;
            end
        end else if (key_enter) begin
            if (m_collect) begin
                if (m_digits.size() == DIGITS) begin
                    packed_pin = '0;
                    foreach (m_digits[i]) packed_pin = (packed_pin << DIGIT_W) | 16'(m_digits[i]);
                    m_code = packed_pin;
                    m_ack_left = ACK_HOLD;
                    m_collect = 0;
                end
                m_digits.delete();
                m_idle = 0;
            end
        end else if (key_valid) begin
            if (!m_collect) begin
                m_collect = 1;
                m_digits.delete();
                m_digits.push_back(int'(key_value));
            end else if (m_digits.size() < DIGITS) begin
                m_digits.push_back(int'(key_value));
            end
            m_idle = 0;
        end else if (m_collect) begin
            m_idle++;
            if (m_idle == ENTRY_TIMEOUT) begin
                m_digits.delete(); m_collect = 0; m_idle = 0;
            end
        end
        // gate
        if (rst) begin
            m_pos = 0; m_up = 0; m_dn = 0; m_ack = 0;
        end else if (m_ack) begin
            m_ack = 0;
        end else if (m_up) begin
            if (close_gate) begin
                m_up = 0;
                if (m_pos == 0) m_ack = 1;
                else m_dn = 1;
            end else begin
                m_pos++;
                if (m_pos == GATE_TRAVEL) m_up = 0;
            end
        end else if (m_dn) begin
            if (open_gate && !close_gate) begin
                m_dn = 0;
                if (m_pos != GATE_TRAVEL) m_up = 1;
            end else begin
                m_pos--;
                if (m_pos == 0) begin
                    m_dn = 0;
                    m_ack = 1;
                end
            end
        end else if (m_pos == GATE_TRAVEL) begin
            if (close_gate) m_dn = 1;
        end else begin
            if (open_gate && !close_gate) m_up = 1;
        end
    endtask

    task automatic compare_model();
        check("m_code",     32'(code),          32'(m_code));
        check("m_code_ack", 32'(code_ack),      32'(m_ack_left > 0));
        check("m_locked",   32'(keypad_locked), 32'(m_locked));
        check("m_motor_up", 32'(motor_up),      32'(m_up));
        check("m_motor_dn", 32'(motor_down),    32'(m_dn));
        check("m_gate_ack", 32'(gate_ack),      32'(m_ack));
        check("m_is_open",  32'(gate_is_open),  32'(m_pos == GATE_TRAVEL));
        if (motor_up && motor_down) check("motor_excl", 32'(1), 32'(0));
    endtask

    // ---------------- driver tasks ----------------
    // Inputs change on the falling edge; outputs are compared on the next one.
    task automatic tick();
        model_step();
        @(posedge clk);
        @(negedge clk);
        compare_model();
    endtask

    task automatic press(input logic [3:0] v);
        key_valid = 1'b1; key_value = v;
        tick();
        key_valid = 1'b0;
    endtask

    task automatic press_enter();
        key_enter = 1'b1;
        tick();
        key_enter = 1'b0;
    endtask

    task automatic press_clear();
        key_clear = 1'b1;
        tick();
        key_clear = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_code"},   32'(code),          32'(0));
        check({tag, "_ack"},    32'(code_ack),      32'(0));
        check({tag, "_gack"},   32'(gate_ack),      32'(0));
        check({tag, "_up"},     32'(motor_up),      32'(0));
        check({tag, "_dn"},     32'(motor_down),    32'(0));
        check({tag, "_open"},   32'(gate_is_open),  32'(0));
        check({tag, "_locked"}, 32'(keypad_locked), 32'(0));
    endtask

    // ---------------- PIN vector table ----------------
    typedef struct {
        int          n;
        logic [3:0]  k [6];
        logic        exp_ack;
        logic [15:0] exp_code;
    } vec_t;

    vec_t tbl [6];

    initial begin
        int n;
        tbl[0].n = 4; tbl[0].k = '{4'h5, 4'h9, 4'h9, 4'h0, 4'h0, 4'h0}; tbl[0].exp_ack = 1; tbl[0].exp_code = 16'h5990;
        tbl[1].n = 2; tbl[1].k = '{4'h1, 4'h2, 4'h0, 4'h0, 4'h0, 4'h0}; tbl[1].exp_ack = 0; tbl[1].exp_code = 16'h0000;
        tbl[2].n = 5; tbl[2].k = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h0}; tbl[2].exp_ack = 1; tbl[2].exp_code = 16'h1234;
        tbl[3].n = 4; tbl[3].k = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0}; tbl[3].exp_ack = 1; tbl[3].exp_code = 16'h0000;
        tbl[4].n = 4; tbl[4].k = '{4'hf, 4'he, 4'hd, 4'hc, 4'h0, 4'h0}; tbl[4].exp_ack = 1; tbl[4].exp_code = 16'hfedc;
        tbl[5].n = 3; tbl[5].k = '{4'ha, 4'hb, 4'hc, 4'h0, 4'h0, 4'h0}; tbl[5].exp_ack = 0; tbl[5].exp_code = 16'h0000;

        rst = 1'b1;
        key_valid = 0; key_value = '0; key_clear = 0; key_enter = 0;
        open_gate = 0; close_gate = 0; wrong_ping = 0; blocked_gate = 0;
        tick();
        check_all_zero("reset");
        rst = 1'b0;
        tick();

        // Table: type the digits, submit, look at the presentation.
        for (int t = 0; t < 6; t++) begin
            for (int j = 0; j < tbl[t].n; j++) press(tbl[t].k[j]);
            press_enter();
            check($sformatf("tbl%0d_ack", t),  32'(code_ack), 32'(tbl[t].exp_ack));
            check($sformatf("tbl%0d_code", t), 32'(code),     32'(tbl[t].exp_code));
            idle(4);
        end
        press_clear();

        // Presentation timing: 2 cycles of code_ack, then a low cycle with code 0.
        press(4'h5); press(4'h9); press(4'h9); press(4'h0);
        press_enter();
        check("pres_ack1", 32'(code_ack), 32'(1));
        check("pres_code", 32'(code), 32'h5990);
        tick();
        check("pres_ack2", 32'(code_ack), 32'(1));
        tick();
        check("pres_low", 32'(code_ack), 32'(0));
        check("pres_zero", 32'(code), 32'(0));
        press(4'h7);                        // ignored during release
        idle(2);

        // Timeout boundary: 63 idle cycles keep the partial PIN.
        press(4'h5); press(4'h9);
        idle(ENTRY_TIMEOUT - 1);
        press(4'h9); press(4'h0);
        press_enter();
        check("to63_code", 32'(code), 32'h5990);
        idle(4);

        // 64 idle cycles discard it.
        press(4'h5); press(4'h9);
        idle(ENTRY_TIMEOUT);
        press(4'h0); press(4'h0); press(4'h9); press(4'h0);
        press_enter();
        check("to64_code", 32'(code), 32'h0090);
        check("to64_ack", 32'(code_ack), 32'(1));
        idle(4);

        // Full open then close.
        open_gate = 1'b1; tick(); open_gate = 1'b0;
        n = 0;
        while (motor_up === 1'b1 && n < 20) begin n++; tick(); end
        check("open_cycles", 32'(n), 32'(GATE_TRAVEL));
        check("is_open", 32'(gate_is_open), 32'(1));
        close_gate = 1'b1; tick();
        n = 0;
        while (motor_down === 1'b1 && n < 20) begin n++; tick(); end
        check("close_cycles", 32'(n), 32'(GATE_TRAVEL));
        check("gate_ack", 32'(gate_ack), 32'(1));
        close_gate = 1'b0; tick();
        check("gate_ack_once", 32'(gate_ack), 32'(0));
        idle(3);

        // Reverse during opening at position 3.
        open_gate = 1'b1; tick(); open_gate = 1'b0;
        idle(3);
        close_gate = 1'b1; tick();
        n = 0;
        while (motor_down === 1'b1 && n < 20) begin n++; tick(); end
        check("rev_cycles", 32'(n), 32'(3));
        check("rev_ack", 32'(gate_ack), 32'(1));
        close_gate = 1'b0; tick();
        check("rev_ack_once", 32'(gate_ack), 32'(0));

        // Alarm during COLLECT locks the keypad until reset.
        press(4'h5); press(4'h9);
        wrong_ping = 1'b1; tick(); wrong_ping = 1'b0;
        check("lock_on", 32'(keypad_locked), 32'(1));
        press(4'h1); press(4'h2); press(4'h3); press(4'h4);
        press_enter();
        check("lock_ack", 32'(code_ack), 32'(0));
        check("lock_code", 32'(code), 32'(0));
        check("lock_held", 32'(keypad_locked), 32'(1));
        rst = 1'b1; tick(); rst = 1'b0;
        check_all_zero("unlock");

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            key_valid    = ($urandom_range(0, 9) < 4);
            key_value    = 4'($urandom_range(0, 15));
            key_clear    = ($urandom_range(0, 39) == 0);
            key_enter    = ($urandom_range(0, 9) == 0);
            open_gate    = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 24) == 0) close_gate = ~close_gate;
            wrong_ping   = ($urandom_range(0, 399) == 0);
            blocked_gate = ($urandom_range(0, 399) == 0);
            rst          = ($urandom_range(0, 249) == 0);
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
